// File: rtl/rng_arb.sv
// rng_arb: round-robin arbiter handing out words from one shared LFSR, with seeding and warm-up control.
// Optional automatic reseed from an entropy input is enabled by defining RNG_ARB_RESEED_EN.
module rng_arb #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int WARMUP_CYC    = 8,
    parameter int RESEED_PERIOD = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  seed_wr_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic [NUM_REQ-1:0]    req_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  lfsr_wr_o,
    output logic [DATA_WIDTH-1:0] lfsr_dat_o,
    input  logic [DATA_WIDTH-1:0] lfsr_dat_i,
`ifdef RNG_ARB_RESEED_EN
    input  logic [DATA_WIDTH-1:0] ent_i,
`endif
    output logic                  ready_o
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SEED, WARMUP, RUN} state_t;

    state_t                state_q;
    logic [7:0]            cnt_q;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d, rdata_q, rdata_d, lfsr_dat_q;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic                  lfsr_wr_q, ready_q, reseed, run_d, found;
    int                    idx;

`ifdef RNG_ARB_RESEED_EN
    localparam int GW = $clog2(RESEED_PERIOD + 1);
    logic [GW-1:0] gcnt_q;
    assign reseed = (state_q == RUN) && (gcnt_q == GW'(RESEED_PERIOD));
    assign seed_d = seed_wr_i ? seed_i : seed_q ^ ent_i;
    // Grants since the last seed load; a full period triggers an automatic reseed
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            gcnt_q <= '0;
        else if (seed_wr_i || reseed)
            gcnt_q <= '0;
        else if (found)
            gcnt_q <= gcnt_q + 1'b1;
    end
`else
    assign reseed = 1'b0;
    assign seed_d = seed_i;
`endif

    // Grants are issued on the edge that enters or stays in RUN, so the first grant lines up with ready_o
    assign run_d = !seed_wr_i && ((state_q == RUN && !reseed) || (state_q == WARMUP && cnt_q == 8'd1));

    // Round-robin search starting at ptr_q; the granted word is the LFSR state sampled on this edge
    always_comb begin
        gnt_d = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (run_d && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_d[idx] = 1'b1;
                ptr_d      = PW'((idx + 1) % NUM_REQ);
            end
        end
        rdata_d = found ? lfsr_dat_i : '0;
    end

    // Control FSM with registered outputs; a seed load (software or automatic) overrides every state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            seed_q     <= '0;
            gnt_q      <= '0;
            rdata_q    <= '0;
            lfsr_wr_q  <= 1'b0;
            lfsr_dat_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            gnt_q      <= gnt_d;
            rdata_q    <= rdata_d;
            ptr_q      <= ptr_d;
            ready_q    <= run_d;
            lfsr_wr_q  <= 1'b0;
            lfsr_dat_q <= '0;
            if (seed_wr_i || reseed) begin
                state_q    <= SEED;
                seed_q     <= seed_d;
                lfsr_wr_q  <= 1'b1;
                lfsr_dat_q <= (seed_d == '0) ? DATA_WIDTH'(1) : seed_d;
            end else begin
                case (state_q)
                    SEED: begin
                        state_q <= WARMUP;
                        cnt_q   <= 8'(WARMUP_CYC);
                    end
                    WARMUP: begin
                        cnt_q <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1)
                            state_q <= RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign gnt_o      = gnt_q;
    assign rdata_o    = rdata_q;
    assign lfsr_wr_o  = lfsr_wr_q;
    assign lfsr_dat_o = lfsr_dat_q;
    assign ready_o    = ready_q;
endmodule
